// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Command-side front end for the 16-bit ALU breadboard. Accepts an op code and
// operand over a valid/ready handshake, drives the ALU inputs for a fixed settle
// window, captures the ALU result and error code, and returns them over a
// valid/ready response channel. Owns the accumulator that feeds ALU input2.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_op (4b), cmd_operand (16b)
//   alu_input1/alu_op_code   registered ALU operand and op code
//   alu_input2               ALU second operand (always the accumulator)
//   alu_output1/alu_err_code ALU result (32b) and error (bit0 ovf, bit1 div0)
//   rsp_valid/rsp_ready      response handshake; rsp_result (32b), rsp_err (2b)
//   acc                      accumulator
//   sticky_err               OR of all response errors since reset or clear
//   op_count                 completed responses, wraps
module alu_cmd_sequencer #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [15:0]      cmd_operand,
  output logic [15:0]      alu_input1,
  output logic [3:0]       alu_op_code,
  output logic [15:0]      alu_input2,
  input  logic [31:0]      alu_output1,
  input  logic [1:0]       alu_err_code,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [1:0]       rsp_err,
  output logic [15:0]      acc,
  output logic [1:0]       sticky_err,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0]       SETTLE_L = 4'(SETTLE);
  localparam logic [3:0]       OP_NOP   = 4'd14;
  localparam logic [3:0]       OP_CLEAR = 4'd13;
  localparam logic [3:0]       OP_RSVD  = 4'd15;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t     state_r;
  logic [3:0] settle_cnt_r;

  // The ALU's second operand is always the accumulator.
  assign alu_input2 = acc;

  // Sequencer FSM with all handshake, ALU-drive and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= 4'd0;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_result   <= 32'd0;
      rsp_err      <= 2'b00;
      alu_input1   <= 16'd0;
      alu_op_code  <= OP_NOP;
      acc          <= 16'd0;
      sticky_err   <= 2'b00;
      op_count     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_op == OP_RSVD) begin
              // Reserved op never reaches the ALU; answer immediately.
              rsp_result <= 32'd0;
              rsp_err    <= 2'b11;
              sticky_err <= sticky_err | 2'b11;
              rsp_valid  <= 1'b1;
              state_r    <= ST_RESP;
            end else begin
              alu_op_code  <= cmd_op;
              alu_input1   <= cmd_operand;
              settle_cnt_r <= SETTLE_L;
              state_r      <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (settle_cnt_r == 4'd1) begin
            rsp_result  <= alu_output1;
            rsp_err     <= alu_err_code;
            rsp_valid   <= 1'b1;
            // Park the ALU on nop while the response waits.
            alu_op_code <= OP_NOP;
            alu_input1  <= 16'd0;
            state_r     <= ST_RESP;
            if (alu_op_code == OP_CLEAR) begin
              // Clear wins over the sticky OR on the same edge.
              acc        <= 16'd0;
              sticky_err <= 2'b00;
            end else begin
              if ((alu_err_code == 2'b00) && (alu_op_code <= 4'd12)) begin
                acc <= alu_output1[15:0];
              end
              sticky_err <= sticky_err | alu_err_code;
            end
          end else begin
            settle_cnt_r <= settle_cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            op_count  <= op_count + CNT_ONE;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
